// File: rtl/clock_core_param.sv
// Parametrised hh:mm:ss time-of-day core with set-mode cursor editing,
// 12/24-h display mapping, a settable hr:min alarm with timed ring, and a day strobe.
module clock_core_param #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TICK_W        = 10,
  parameter int ALARM_SEC     = 30
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_tick_en,
  input  logic       i_set,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode_12h,
  input  logic       i_alarm_en,
  input  logic       i_alarm_ack,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic [4:0] o_disp_hr,
  output logic       o_pm,
  output logic [5:0] o_al_min,
  output logic [4:0] o_al_hr,
  output logic [1:0] o_mode,
  output logic [1:0] o_cursor,
  output logic       o_alarm,
  output logic       o_day
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  localparam logic [1:0]        CUR_SEC   = 2'd0;
  localparam logic [1:0]        CUR_MIN   = 2'd1;
  localparam logic [1:0]        CUR_HR    = 2'd2;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [5:0]        RING_INIT = 6'(ALARM_SEC);

  mode_t             mode_reg;
  logic [1:0]        cursor_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [5:0]        sec_reg;
  logic [5:0]        min_reg;
  logic [4:0]        hr_reg;
  logic [5:0]        al_min_reg;
  logic [4:0]        al_hr_reg;
  logic              alarm_reg;
  logic [5:0]        ring_reg;
  logic              day_reg;

  logic       running;
  logic       tick_wrap;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hr_wrap;
  logic       edit_en;
  logic       up_pulse;
  logic       dn_pulse;
  logic       mv_right;
  logic       mv_left;
  logic       enter_set_time;
  logic       trigger;
  logic [5:0] sec_up, sec_dn, min_up, min_dn, al_min_up, al_min_dn;
  logic [4:0] hr_up, hr_dn, al_hr_up, al_hr_dn;
  logic [5:0] min_after;
  logic [4:0] hr_after;
  logic [1:0] cursor_right;
  logic [1:0] cursor_left;

  // The sub-second counter is frozen only while the time itself is being set.
  assign running        = (mode_reg != MODE_SET_TIME);
  assign tick_wrap      = running && i_tick_en && (tick_reg == TICK_MAX);
  assign sec_wrap       = tick_wrap && (sec_reg == 6'd59);
  assign min_wrap       = sec_wrap && (min_reg == 6'd59);
  assign hr_wrap        = min_wrap && (hr_reg == 5'd23);

  assign edit_en        = !i_set && (mode_reg != MODE_RUN);
  assign up_pulse       = edit_en && i_up && !i_down;
  assign dn_pulse       = edit_en && i_down && !i_up;
  assign mv_right       = edit_en && i_right && !i_left;
  assign mv_left        = edit_en && i_left && !i_right;
  assign enter_set_time = i_set && (mode_reg == MODE_RUN);

  assign sec_up    = (sec_reg == 6'd59)    ? 6'd0  : sec_reg + 6'd1;
  assign sec_dn    = (sec_reg == 6'd0)     ? 6'd59 : sec_reg - 6'd1;
  assign min_up    = (min_reg == 6'd59)    ? 6'd0  : min_reg + 6'd1;
  assign min_dn    = (min_reg == 6'd0)     ? 6'd59 : min_reg - 6'd1;
  assign hr_up     = (hr_reg == 5'd23)     ? 5'd0  : hr_reg + 5'd1;
  assign hr_dn     = (hr_reg == 5'd0)      ? 5'd23 : hr_reg - 5'd1;
  assign al_min_up = (al_min_reg == 6'd59) ? 6'd0  : al_min_reg + 6'd1;
  assign al_min_dn = (al_min_reg == 6'd0)  ? 6'd59 : al_min_reg - 6'd1;
  assign al_hr_up  = (al_hr_reg == 5'd23)  ? 5'd0  : al_hr_reg + 5'd1;
  assign al_hr_dn  = (al_hr_reg == 5'd0)   ? 5'd23 : al_hr_reg - 5'd1;

  // Alarm compares against the time as it will be after this edge's rollover.
  assign min_after = sec_wrap ? min_up : min_reg;
  assign hr_after  = min_wrap ? hr_up : hr_reg;
  assign trigger   = sec_wrap && i_alarm_en &&
                     (hr_after == al_hr_reg) && (min_after == al_min_reg);

  always_comb begin
    cursor_right = CUR_SEC;
    cursor_left  = CUR_SEC;
    if (mode_reg == MODE_SET_ALARM) begin
      // Alarm has no seconds field: the cursor just toggles MIN/HR.
      cursor_right = (cursor_reg == CUR_HR) ? CUR_MIN : CUR_HR;
      cursor_left  = (cursor_reg == CUR_HR) ? CUR_MIN : CUR_HR;
    end else begin
      unique case (cursor_reg)
        CUR_SEC: begin cursor_right = CUR_MIN; cursor_left = CUR_HR;  end
        CUR_MIN: begin cursor_right = CUR_HR;  cursor_left = CUR_SEC; end
        CUR_HR:  begin cursor_right = CUR_SEC; cursor_left = CUR_MIN; end
        default: begin cursor_right = CUR_SEC; cursor_left = CUR_SEC; end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_reg   <= MODE_RUN;
      cursor_reg <= CUR_SEC;
      tick_reg   <= '0;
      sec_reg    <= 6'd0;
      min_reg    <= 6'd0;
      hr_reg     <= 5'd0;
      al_min_reg <= 6'd0;
      al_hr_reg  <= 5'd0;
      alarm_reg  <= 1'b0;
      ring_reg   <= 6'd0;
      day_reg    <= 1'b0;
    end else begin
      if (i_set) begin
        unique case (mode_reg)
          MODE_RUN: begin
            mode_reg   <= MODE_SET_TIME;
            cursor_reg <= CUR_SEC;
          end
          MODE_SET_TIME: begin
            mode_reg   <= MODE_SET_ALARM;
            cursor_reg <= CUR_MIN;
          end
          default: mode_reg <= MODE_RUN;
        endcase
      end else if (mv_right) begin
        cursor_reg <= cursor_right;
      end else if (mv_left) begin
        cursor_reg <= cursor_left;
      end

      if (enter_set_time) begin
        tick_reg <= '0;
      end else if (running && i_tick_en) begin
        tick_reg <= (tick_reg == TICK_MAX) ? '0 : tick_reg + TICK_ONE;
      end

      if (mode_reg == MODE_SET_TIME) begin
        if (up_pulse || dn_pulse) begin
          unique case (cursor_reg)
            CUR_SEC: sec_reg <= up_pulse ? sec_up : sec_dn;
            CUR_MIN: min_reg <= up_pulse ? min_up : min_dn;
            CUR_HR:  hr_reg  <= up_pulse ? hr_up  : hr_dn;
            default: ;
          endcase
        end
      end else if (tick_wrap) begin
        sec_reg <= sec_up;
        if (sec_wrap) min_reg <= min_up;
        if (min_wrap) hr_reg  <= hr_up;
      end

      if (mode_reg == MODE_SET_ALARM && (up_pulse || dn_pulse)) begin
        if (cursor_reg == CUR_HR) al_hr_reg  <= up_pulse ? al_hr_up  : al_hr_dn;
        else                      al_min_reg <= up_pulse ? al_min_up : al_min_dn;
      end

      day_reg <= hr_wrap;

      // Silencing conditions beat a same-cycle trigger.
      if (enter_set_time || i_alarm_ack || !i_alarm_en) begin
        alarm_reg <= 1'b0;
      end else if (trigger) begin
        alarm_reg <= 1'b1;
        ring_reg  <= RING_INIT;
      end else if (alarm_reg && tick_wrap) begin
        if (ring_reg <= 6'd1) alarm_reg <= 1'b0;
        ring_reg <= (ring_reg == 6'd0) ? 6'd0 : ring_reg - 6'd1;
      end
    end
  end

  always_comb begin
    o_disp_hr = hr_reg;
    if (i_mode_12h) begin
      if (hr_reg == 5'd0)      o_disp_hr = 5'd12;
      else if (hr_reg > 5'd12) o_disp_hr = hr_reg - 5'd12;
    end
  end

  assign o_pm     = (hr_reg >= 5'd12);
  assign o_sec    = sec_reg;
  assign o_min    = min_reg;
  assign o_hr     = hr_reg;
  assign o_al_min = al_min_reg;
  assign o_al_hr  = al_hr_reg;
  assign o_mode   = mode_reg;
  assign o_cursor = cursor_reg;
  assign o_alarm  = alarm_reg;
  assign o_day    = day_reg;

endmodule

// File: doc/clock_core_param.md
Name: clock_core_param

Overview:
- Parametrised successor to the fixed ms/sec/min/hr clock.
- Tick depth is set by parameter. Adds a 12/24-h display mode, a field cursor for setting time, a separately settable alarm (hr:min) with timed ring output, and a day-rollover strobe.
- Sits between the debounced button front-end and the display/segment driver; one instance per clock face.

Parameters:
TICKS_PER_SEC, 1000, i_tick_en strobes per second; sub-second counter wraps at TICKS_PER_SEC-1
TICK_W, 10, sub-second counter width; must satisfy 2^TICK_W >= TICKS_PER_SEC
ALARM_SEC, 30, seconds o_alarm stays asserted unless acknowledged (1..63)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_tick_en  in  1  sub-second strobe (1 ms at default), one cycle wide
i_set  in  1  mode-advance pulse
i_up  in  1  increment selected field, pulse
i_down  in  1  decrement selected field, pulse
i_left  in  1  cursor left, pulse
i_right  in  1  cursor right, pulse
i_mode_12h  in  1  1 = 12-h display, 0 = 24-h
i_alarm_en  in  1  alarm arm level
i_alarm_ack  in  1  silence ringing alarm, pulse
o_sec  out  6  seconds 0..59
o_min  out  6  minutes 0..59
o_hr  out  5  hours 0..23, internal 24-h value
o_disp_hr  out  5  display hour: 0..23 (24-h) or 1..12 (12-h)
o_pm  out  1  o_hr >= 12, independent of mode
o_al_min  out  6  alarm minute
o_al_hr  out  5  alarm hour, 24-h
o_mode  out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM
o_cursor  out  2  0 SEC, 1 MIN, 2 HR
o_alarm  out  1  alarm ringing
o_day  out  1  one-cycle strobe on 23:59:59 -> 00:00:00

Behaviour:
- Reset (asynchronous, i_rstn low): all counters, alarm registers, o_mode, o_cursor = 0. o_alarm and o_day = 0. o_disp_hr = 0 (24-h) or 12 (12-h). All buttons are single-cycle pulses, already synchronised and debounced.
- Sub-second counter: in RUN and SET_ALARM, advances on i_tick_en. On i_tick_en at TICKS_PER_SEC-1 it wraps to 0 and issues a sec carry in the same cycle.
- Carry chain, all registered in one cycle:
  - sec 59 + carry -> 0 with min carry; min 59 -> 0 with hr carry; hr 23 -> 0 with o_day = 1 for that cycle.
  - No extra latency per stage: time updates on the clock edge following the tick.
- Mode FSM:
  - i_set advances RUN -> SET_TIME -> SET_ALARM -> RUN.
  - Entering SET_TIME: cursor = SEC; sub-second counter cleared and frozen; time does not advance.
  - Leaving SET_TIME: sub-second counter restarts from 0.
  - Entering SET_ALARM: cursor = MIN; time keeps running.
- Cursor:
  - i_right: SEC->MIN->HR->SEC. i_left is the reverse.
  - In SET_ALARM, SEC is skipped (MIN<->HR only).
  - Ignored in RUN.
- Field edit:
  - i_up / i_down change only the selected field, with wrap: sec/min 59<->0, hr 23<->0.
  - No carry or borrow into neighbouring fields.
  - SET_TIME edits time registers; SET_ALARM edits alarm registers. Ignored in RUN.
- Simultaneous pulses:
  - i_set wins; all other buttons are ignored that cycle.
  - i_left+i_right together: no cursor move.
  - i_up+i_down together: no change.
  - Cursor move and field edit in the same cycle: edit applies to the old cursor field; cursor then moves.
- Alarm:
  - Trigger: a seconds rollover to 0 in RUN or SET_ALARM where the resulting {hr,min} equals {al_hr,al_min} and i_alarm_en = 1. o_alarm rises on the same edge as the time update.
  - No trigger in SET_TIME, even if edits land on the match.
  - Ring timer reloads to ALARM_SEC on trigger and decrements on each sec carry.
  - o_alarm clears on the edge after: i_alarm_ack, timer reaching 0, i_alarm_en low, or a transition into SET_TIME.
  - Retrigger while ringing reloads the timer.
- 12-h mapping: hr 0 -> 12; 1..12 -> same; 13..23 -> hr-12. Combinational from o_hr and i_mode_12h; no added latency.
- Reset mid-operation clears everything immediately, including an active ring and set mode.

Test Plan:
1. TICKS_PER_SEC=4. Preload 23:59:59, hold i_tick_en high for 4 cycles -> 00:00:00 on the edge after the 4th tick; o_day high exactly 1 cycle.
2. i_set once, i_right once (cursor MIN), i_down at min=0 -> min 59, hr unchanged. 10 i_tick_en -> time frozen. i_set twice -> RUN, seconds resume after 4 ticks.
3. SET_ALARM: cursor starts at 1; i_right -> 2; i_up x7 -> al_hr 7; i_left -> 1; i_up x30 -> al_min 30. RUN at 07:29:59 with i_alarm_en=1, 4 ticks -> o_alarm=1 at 07:30:00.
4. Ringing with ALARM_SEC=3 -> o_alarm clears after 3 sec carries. Repeat with i_alarm_ack at 1 sec -> clears on the next edge.
5. i_mode_12h=1: hr 0/12/13/23 -> o_disp_hr 12/12/1/11, o_pm 0/1/1/1. Toggling mode leaves o_hr unchanged.
6. Same-cycle i_set+i_up in SET_TIME -> mode advances, field unchanged. i_up+i_down -> no change. Assert i_rstn low while ringing in SET_ALARM -> all outputs at reset values asynchronously.
